// File: rtl/timer_reload_ctrl.sv
// ---------------------------------------------------------------------------
// timer_reload_ctrl
//
// Control stage in front of an n-bit up/down counter (ld, D, up, rco). It
// drives the counter's load, data and direction inputs and watches its
// terminal-count flag, so the counter becomes a programmable interval timer
// that runs in periodic or one-shot mode. Each terminal count in RUN raises
// a level interrupt that is held until acknowledged. A sticky overrun flag
// records an expiry that arrived while the interrupt was still pending.
//
// Ports
//   clk        in   system clock, shared with the counter
//   clr        in   asynchronous active-high reset
//   cfg_we     in   configuration write strobe
//   cfg_reload in   reload value (n bits), captured on cfg_we
//   cfg_mode   in   0 = periodic, 1 = one-shot, captured on cfg_we
//   cfg_dir    in   1 = count up, 0 = count down, captured on cfg_we
//   start      in   single-cycle start request
//   stop       in   single-cycle stop request (wins over start/expiry exit)
//   rco        in   counter terminal-count flag (combinational)
//   intr_ack   in   CPU acknowledge, clears intr and ovr
//   cntr_ld    out  counter load enable
//   cntr_D     out  counter load value (= reload register)
//   cntr_up    out  counter direction, frozen while running
//   intr       out  interrupt request, level
//   ovr        out  sticky overrun
//   busy       out  high while in RUN
//   done       out  high while in DONE (one-shot expired)
// ---------------------------------------------------------------------------
module timer_reload_ctrl #(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         cfg_we,
    input  logic [n-1:0] cfg_reload,
    input  logic         cfg_mode,
    input  logic         cfg_dir,
    input  logic         start,
    input  logic         stop,
    input  logic         rco,
    input  logic         intr_ack,
    output logic         cntr_ld,
    output logic [n-1:0] cntr_D,
    output logic         cntr_up,
    output logic         intr,
    output logic         ovr,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t       state_q, state_d;
    logic [n-1:0] reload_q, reload_d;
    logic         mode_q, mode_d;
    logic         dir_q, dir_d;
    logic         up_q, up_d;
    logic         intr_q, intr_d;
    logic         ovr_q, ovr_d;
    logic         expiry;

    // An expiry only counts while the timer is actually running; in IDLE and
    // DONE the counter is held by ld and rco is meaningless.
    assign expiry = (state_q == RUN) && rco;

    always_comb begin
        state_d  = state_q;
        reload_d = reload_q;
        mode_d   = mode_q;
        dir_d    = dir_q;
        up_d     = up_q;
        intr_d   = intr_q;
        ovr_d    = ovr_q;

        if (cfg_we) begin
            reload_d = cfg_reload;
            mode_d   = cfg_mode;
            dir_d    = cfg_dir;
        end

        // Direction is sampled only outside RUN (including the start edge),
        // so a configuration write can never reverse a run in progress.
        if (state_q != RUN) begin
            up_d = dir_q;
        end

        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (rco && mode_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (start) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // An ack together with a new expiry consumes the old event and leaves
        // the new one pending, so overrun is cleared but intr stays set.
        if (expiry) begin
            intr_d = 1'b1;
            if (intr_ack) begin
                ovr_d = 1'b0;
            end else begin
                ovr_d = ovr_q | intr_q;
            end
        end else if (intr_ack) begin
            intr_d = 1'b0;
            ovr_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= IDLE;
            reload_q <= '0;
            mode_q   <= 1'b0;
            dir_q    <= 1'b0;
            up_q     <= 1'b0;
            intr_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            reload_q <= reload_d;
            mode_q   <= mode_d;
            dir_q    <= dir_d;
            up_q     <= up_d;
            intr_q   <= intr_d;
            ovr_q    <= ovr_d;
        end
    end

    // Outside RUN the counter is held at the reload value; in RUN it reloads
    // on the edge after terminal count, so it never wraps.
    assign cntr_ld = (state_q == RUN) ? rco : 1'b1;
    assign cntr_D  = reload_q;
    assign cntr_up = up_q;
    assign intr    = intr_q;
    assign ovr     = ovr_q;
    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);

endmodule

// File: tb/tb_timer_reload_ctrl.sv
module tb_timer_reload_ctrl;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         clr = 1'b1;
    logic         cfg_we = 1'b0;
    logic [N-1:0] cfg_reload = '0;
    logic         cfg_mode = 1'b0;
    logic         cfg_dir = 1'b0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         rco;
    logic         intr_ack = 1'b0;
    logic         cntr_ld;
    logic [N-1:0] cntr_D;
    logic         cntr_up;
    logic         intr;
    logic         ovr;
    logic         busy;
    logic         done;

    logic [N-1:0] count;
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    timer_reload_ctrl #(.n(N)) dut (
        .clk       (clk),
        .clr       (clr),
        .cfg_we    (cfg_we),
        .cfg_reload(cfg_reload),
        .cfg_mode  (cfg_mode),
        .cfg_dir   (cfg_dir),
        .start     (start),
        .stop      (stop),
        .rco       (rco),
        .intr_ack  (intr_ack),
        .cntr_ld   (cntr_ld),
        .cntr_D    (cntr_D),
        .cntr_up   (cntr_up),
        .intr      (intr),
        .ovr       (ovr),
        .busy      (busy),
        .done      (done)
    );

    // Downstream up/down counter the controller drives.
    always_ff @(posedge clk or posedge clr) begin
        if (clr)          count <= '0;
        else if (cntr_ld) count <= cntr_D;
        else if (cntr_up) count <= count + 8'd1;
        else              count <= count - 8'd1;
    end
    assign rco = cntr_up ? (count == 8'hFF) : (count == 8'h00);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    task automatic configure(input logic [N-1:0] rl, input logic md, input logic dr);
        cfg_we = 1'b1; cfg_reload = rl; cfg_mode = md; cfg_dir = dr;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic do_ack();
        intr_ack = 1'b1;
        tick();
        intr_ack = 1'b0;
    endtask

    task automatic test_reset();
        tick_n(2);
        checks++;
        if ({intr, ovr, busy, done} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got %b want 0000", {intr, ovr, busy, done});
        end
        checks++;
        if ({cntr_ld, cntr_up} !== 2'b10 || cntr_D !== 8'd0) begin
            errors++; $display("FAIL reset_cntr: ld=%b up=%b D=%0d want ld=1 up=0 D=0", cntr_ld, cntr_up, cntr_D);
        end
        clr = 1'b0;
        tick();
        checks++;
        if (cntr_ld !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset: ld=%b busy=%b want 1 0", cntr_ld, busy);
        end
    endtask

    task automatic test_periodic_down();
        int cyc;
        configure(8'd5, 1'b0, 1'b0);
        tick();
        checks++;
        if (cntr_ld !== 1'b1 || count !== 8'd5) begin
            errors++; $display("FAIL idle_hold: ld=%b count=%0d want 1 5", cntr_ld, count);
        end
        do_start();
        checks++;
        if (busy !== 1'b1 || count !== 8'd5) begin
            errors++; $display("FAIL start_down: busy=%b count=%0d want 1 5", busy, count);
        end
        for (int v = 4; v >= 0; v--) begin
            tick();
            checks++;
            if (count !== v[7:0] || intr !== 1'b0) begin
                errors++; $display("FAIL down_seq: count=%0d intr=%b want %0d 0", count, intr, v);
            end
        end
        tick();
        checks++;
        if (intr !== 1'b1 || count !== 8'd5) begin
            errors++; $display("FAIL down_expiry: intr=%b count=%0d want 1 5", intr, count);
        end
        do_ack();
        checks++;
        if (intr !== 1'b0) begin
            errors++; $display("FAIL down_ack: intr=%b want 0", intr);
        end
        cyc = 1;
        while (intr !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        checks++;
        if (cyc !== 6) begin
            errors++; $display("FAIL down_period: got %0d cycles want 6", cyc);
        end
        do_stop();
        do_ack();
        checks++;
        if ({busy, intr, ovr} !== 3'b000) begin
            errors++; $display("FAIL down_stop: busy/intr/ovr=%b want 000", {busy, intr, ovr});
        end
    endtask

    task automatic test_up_count();
        logic [N-1:0] exp_cnt;
        configure(8'd250, 1'b0, 1'b1);
        tick();
        checks++;
        if (cntr_up !== 1'b1 || count !== 8'd250) begin
            errors++; $display("FAIL up_idle: up=%b count=%0d want 1 250", cntr_up, count);
        end
        do_start();
        for (int i = 1; i <= 6; i++) begin
            tick();
            exp_cnt = (i == 6) ? 8'd250 : 8'(250 + i);
            checks++;
            if (count !== exp_cnt || cntr_up !== 1'b1 || busy !== 1'b1) begin
                errors++; $display("FAIL up_seq: count=%0d up=%b busy=%b want %0d 1 1", count, cntr_up, busy, exp_cnt);
            end
        end
        checks++;
        if (intr !== 1'b1) begin
            errors++; $display("FAIL up_expiry: intr=%b want 1", intr);
        end
        do_stop();
        do_ack();
    endtask

    task automatic test_one_shot();
        int cyc;
        configure(8'd3, 1'b1, 1'b0);
        tick();
        do_start();
        for (int v = 2; v >= 0; v--) begin
            tick();
            checks++;
            if (count !== v[7:0] || busy !== 1'b1) begin
                errors++; $display("FAIL os_seq: count=%0d busy=%b want %0d 1", count, busy, v);
            end
        end
        tick();
        checks++;
        if ({done, busy, intr} !== 3'b101 || count !== 8'd3) begin
            errors++; $display("FAIL os_done: done/busy/intr=%b count=%0d want 101 3", {done, busy, intr}, count);
        end
        tick();
        checks++;
        if (done !== 1'b1 || count !== 8'd3) begin
            errors++; $display("FAIL os_hold: done=%b count=%0d want 1 3", done, count);
        end
        do_ack();
        do_start();
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || count !== 8'd3) begin
            errors++; $display("FAIL os_rearm: busy=%b done=%b count=%0d want 1 0 3", busy, done, count);
        end
        cyc = 0;
        while (done !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        checks++;
        if (cyc !== 4 || intr !== 1'b1 || ovr !== 1'b0) begin
            errors++; $display("FAIL os_rerun: cycles=%0d intr=%b ovr=%b want 4 1 0", cyc, intr, ovr);
        end
        do_stop();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL os_stop: done=%b busy=%b want 0 0", done, busy);
        end
        do_ack();
    endtask

    task automatic test_overrun();
        configure(8'd2, 1'b0, 1'b0);
        tick();
        do_start();
        tick_n(3);
        checks++;
        if ({intr, ovr} !== 2'b10 || count !== 8'd2) begin
            errors++; $display("FAIL ovr_first: intr/ovr=%b count=%0d want 10 2", {intr, ovr}, count);
        end
        tick_n(3);
        checks++;
        if ({intr, ovr} !== 2'b11) begin
            errors++; $display("FAIL ovr_second: intr/ovr=%b want 11", {intr, ovr});
        end
        do_ack();
        checks++;
        if ({intr, ovr} !== 2'b00) begin
            errors++; $display("FAIL ovr_ack: intr/ovr=%b want 00", {intr, ovr});
        end
        // count is 1 here; two expiries later ovr is set again
        tick_n(2);
        tick_n(3);
        checks++;
        if ({intr, ovr} !== 2'b11 || count !== 8'd2) begin
            errors++; $display("FAIL ovr_again: intr/ovr=%b count=%0d want 11 2", {intr, ovr}, count);
        end
        tick_n(2);
        do_ack();
        checks++;
        if ({intr, ovr} !== 2'b10) begin
            errors++; $display("FAIL ack_with_expiry: intr/ovr=%b want 10", {intr, ovr});
        end
        do_stop();
        do_ack();
    endtask

    task automatic test_stop_on_expiry();
        configure(8'd1, 1'b1, 1'b0);
        tick();
        do_start();
        tick();
        checks++;
        if (count !== 8'd0 || cntr_ld !== 1'b1) begin
            errors++; $display("FAIL pre_stop: count=%0d ld=%b want 0 1", count, cntr_ld);
        end
        do_stop();
        checks++;
        if ({busy, done, intr} !== 3'b001) begin
            errors++; $display("FAIL stop_expiry: busy/done/intr=%b want 001", {busy, done, intr});
        end
        do_ack();
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL start_stop_idle: busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_clr_mid_run();
        configure(8'd9, 1'b0, 1'b0);
        tick();
        do_start();
        configure(8'd9, 1'b0, 1'b1);
        checks++;
        if (cntr_up !== 1'b0 || count !== 8'd8) begin
            errors++; $display("FAIL dir_frozen: up=%b count=%0d want 0 8", cntr_up, count);
        end
        tick_n(6);
        checks++;
        if (count !== 8'd2 || busy !== 1'b1 || cntr_up !== 1'b0) begin
            errors++; $display("FAIL pre_clr: count=%0d busy=%b up=%b want 2 1 0", count, busy, cntr_up);
        end
        #1 clr = 1'b1;
        #1;
        checks++;
        if ({intr, busy, cntr_ld} !== 3'b001 || cntr_D !== 8'd0) begin
            errors++; $display("FAIL async_clr: intr/busy/ld=%b D=%0d want 001 0", {intr, busy, cntr_ld}, cntr_D);
        end
        tick_n(2);
        clr = 1'b0;
        tick_n(2);
        checks++;
        if ({intr, ovr, busy, done} !== 4'b0000) begin
            errors++; $display("FAIL after_clr: flags=%b want 0000", {intr, ovr, busy, done});
        end
    endtask

    initial begin
        test_reset();
        test_periodic_down();
        test_up_count();
        test_one_shot();
        test_overrun();
        test_stop_on_expiry();
        test_clr_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
